// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: fetch handshake, two-word ops,
// multi-cycle MUL/DIV, separate write-back. Optional trap state via CU_ILLEGAL_TRAP_EN.
module cpu_ctrl_fsm #(
   parameter int OPCODE_W   = 4,
   parameter int ALU_MODE_W = 2,
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = $clog2(MULDIV_LAT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  imem_valid,
   input  logic [OPCODE_W-1:0]   opcode,
   output logic [ALU_MODE_W-1:0] alu_mode,
   output logic                  ins_load,
   output logic                  op1_load,
   output logic                  op2_load,
   output logic                  pc_load,
   output logic                  pc_inc,
   output logic                  reg_load,
   output logic                  busy,
   output logic                  trap
);

   typedef enum logic [2:0] {
      StReset, StFetch, StExtFetch, StExec, StWb, StTrap
   } state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(MULDIV_LAT - 1);

   state_e              state_q;
   logic [OPCODE_W-1:0] op_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [3:0]          op_lo;
   logic [1:0]          mode;

   function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
      return ((op >> 4) != '0) || (op[3:1] == 3'b111);
   endfunction

   function automatic logic is_ext(input logic [OPCODE_W-1:0] op);
      return !is_illegal(op) && (op[3:1] == 3'b110);
   endfunction

   assign op_lo = op_q[3:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StReset;
         op_q    <= '0;
         cnt_q   <= '0;
      end else if (en) begin
         case (state_q)
            StReset: state_q <= StFetch;
            StFetch: begin
               if (imem_valid) begin
                  op_q <= opcode;
                  if (is_illegal(opcode)) begin
`ifdef CU_ILLEGAL_TRAP_EN
                     state_q <= StTrap;
`else
                     state_q <= StFetch;
`endif
                  end else if (is_ext(opcode)) begin
                     state_q <= StExtFetch;
                  end else begin
                     state_q <= StExec;
                  end
               end
            end
            StExtFetch: if (imem_valid) state_q <= StExec;
            StExec: begin
               // MUL (0001) and DIV (0011) hold EXEC for MULDIV_LAT cycles
               if ((op_lo[3:2] != 2'b00) || !op_lo[0] || (cnt_q == CntLast)) begin
                  cnt_q   <= '0;
                  state_q <= StWb;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWb: state_q <= StFetch;
`ifdef CU_ILLEGAL_TRAP_EN
            StTrap: state_q <= StTrap;
`endif
            default: state_q <= StReset;
         endcase
      end
   end

   always_comb begin
      mode = 2'b00;
      if (op_lo <= 4'd3)       mode = 2'b01;
      else if (op_lo <= 4'd10) mode = 2'b10;
   end

   always_comb begin
      alu_mode = '0;
      ins_load = 1'b0;
      op1_load = 1'b0;
      op2_load = 1'b0;
      pc_load  = 1'b0;
      pc_inc   = 1'b0;
      reg_load = 1'b0;
      busy     = (state_q != StReset);
`ifdef CU_ILLEGAL_TRAP_EN
      trap     = (state_q == StTrap);
`else
      trap     = 1'b0;
`endif
      case (state_q)
         StFetch: begin
            pc_load  = en;
            ins_load = en && imem_valid;
            pc_inc   = en && imem_valid;
         end
         StExtFetch: begin
            pc_load  = en;
            ins_load = en && imem_valid;
            pc_inc   = en && imem_valid;
            op1_load = en && imem_valid && (op_lo == 4'b1100);
         end
         StExec: begin
            alu_mode = ALU_MODE_W'(mode);
            // Operand strobes only on the first EXEC cycle
            op1_load = en && (cnt_q == '0) && ((op_lo <= 4'd7) || (op_lo == 4'd9) ||
                                                (op_lo == 4'd10));
            op2_load = en && (cnt_q == '0) && ((op_lo <= 4'd6) ||
                                                ((op_lo >= 4'd8) && (op_lo <= 4'd11)));
         end
         StWb: begin
            alu_mode = ALU_MODE_W'(mode);
            reg_load = en;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_cpu_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst, en, imem_valid;
   logic [3:0] opcode;
   logic [1:0] alu_mode;
   logic       ins_load, op1_load, op2_load, pc_load, pc_inc, reg_load, busy, trap;

   typedef struct {
      logic       chk;
      logic [9:0] exp;
      string      name;
   } entry_t;

   entry_t sb[$];
   int     checks = 0;
   int     errors = 0;

   cpu_ctrl_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .imem_valid (imem_valid),
      .opcode     (opcode),
      .alu_mode   (alu_mode),
      .ins_load   (ins_load),
      .op1_load   (op1_load),
      .op2_load   (op2_load),
      .pc_load    (pc_load),
      .pc_inc     (pc_inc),
      .reg_load   (reg_load),
      .busy       (busy),
      .trap       (trap)
   );

   always #5 clk = ~clk;

   // {busy, trap, alu_mode, ins, op1, op2, pc_load, pc_inc, reg}
   function automatic logic [9:0] ex(input logic b, input logic t, input logic [1:0] m,
                                     input logic i, input logic o1, input logic o2,
                                     input logic pl, input logic pi, input logic r);
      return {b, t, m, i, o1, o2, pl, pi, r};
   endfunction

   task automatic cyc(input logic r, input logic e, input logic v, input logic [3:0] op,
                      input logic chk, input logic [9:0] exp, input string name);
      entry_t ent;
      @(posedge clk);
      #1;
      rst        = r;
      en         = e;
      imem_valid = v;
      opcode     = op;
      ent.chk    = chk;
      ent.exp    = exp;
      ent.name   = name;
      sb.push_back(ent);
   endtask

   always @(negedge clk) begin
      entry_t ent;
      logic [9:0] got;
      if (sb.size() > 0) begin
         ent = sb.pop_front();
         got = {busy, trap, alu_mode, ins_load, op1_load, op2_load, pc_load, pc_inc, reg_load};
         if (ent.chk) begin
            checks++;
            if (got !== ent.exp) begin
               errors++;
               $display("FAIL %s: got %b expected %b", ent.name, got, ent.exp);
            end
         end
      end
   end

   localparam logic [9:0] Zero = 10'b0;

   initial begin
      rst = 1'b1; en = 1'b0; imem_valid = 1'b1; opcode = 4'b0000;
      cyc(1, 0, 1, 4'b0000, 0, Zero, "rst0");
      cyc(1, 1, 1, 4'b0000, 1, Zero, "rst1");
      cyc(0, 1, 1, 4'b0000, 1, Zero, "reset_idle");
      // ADD
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b00, 1, 0, 0, 1, 1, 0), "add_fetch");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 1, 1, 0, 0, 0), "add_exec");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 0, 0, 0, 0, 1), "add_wb");
      // MUL with en dropped mid-count
      cyc(0, 1, 1, 4'b0001, 1, ex(1, 0, 2'b00, 1, 0, 0, 1, 1, 0), "mul_fetch");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 1, 1, 0, 0, 0), "mul_exec0");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 0, 0, 0, 0, 0), "mul_exec1");
      for (int k = 0; k < 3; k++)
         cyc(0, 0, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 0, 0, 0, 0, 0), "mul_en_low");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 0, 0, 0, 0, 0), "mul_exec2");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 0, 0, 0, 0, 0), "mul_exec3");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 0, 0, 0, 0, 1), "mul_wb");
      // MVI with stalled second word; opcode changes must not overwrite op_q
      cyc(0, 1, 1, 4'b1100, 1, ex(1, 0, 2'b00, 1, 0, 0, 1, 1, 0), "mvi_fetch");
      cyc(0, 1, 0, 4'b0001, 1, ex(1, 0, 2'b00, 0, 0, 0, 1, 0, 0), "mvi_stall0");
      cyc(0, 1, 0, 4'b0001, 1, ex(1, 0, 2'b00, 0, 0, 0, 1, 0, 0), "mvi_stall1");
      cyc(0, 1, 1, 4'b0001, 1, ex(1, 0, 2'b00, 1, 1, 0, 1, 1, 0), "mvi_word2");
      cyc(0, 1, 1, 4'b0001, 1, ex(1, 0, 2'b00, 0, 0, 0, 0, 0, 0), "mvi_exec");
      cyc(0, 1, 1, 4'b0001, 1, ex(1, 0, 2'b00, 0, 0, 0, 0, 0, 1), "mvi_wb");
      // Fetch stall then XOR
      cyc(0, 1, 0, 4'b1001, 1, ex(1, 0, 2'b00, 0, 0, 0, 1, 0, 0), "fetch_stall");
      cyc(0, 1, 1, 4'b1001, 1, ex(1, 0, 2'b00, 1, 0, 0, 1, 1, 0), "xor_fetch");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b10, 0, 1, 1, 0, 0, 0), "xor_exec");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b10, 0, 0, 0, 0, 0, 1), "xor_wb");
      // 1011: addressing mode, op2 only
      cyc(0, 1, 1, 4'b1011, 1, ex(1, 0, 2'b00, 1, 0, 0, 1, 1, 0), "b_fetch");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b00, 0, 0, 1, 0, 0, 0), "b_exec");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b00, 0, 0, 0, 0, 0, 1), "b_wb");
      // Illegal opcode
      cyc(0, 1, 1, 4'b1111, 1, ex(1, 0, 2'b00, 1, 0, 0, 1, 1, 0), "ill_fetch");
`ifdef CU_ILLEGAL_TRAP_EN
      for (int k = 0; k < 10; k++)
         cyc(0, 1, 1, 4'b0000, 1, ex(1, 1, 2'b00, 0, 0, 0, 0, 0, 0), "trap_hold");
      cyc(1, 1, 1, 4'b0000, 1, ex(1, 1, 2'b00, 0, 0, 0, 0, 0, 0), "trap_rst");
      cyc(0, 1, 1, 4'b0000, 1, Zero, "trap_cleared");
`else
      cyc(0, 1, 0, 4'b0000, 1, ex(1, 0, 2'b00, 0, 0, 0, 1, 0, 0), "ill_refetch");
`endif
      // rst during MUL EXEC abandons the instruction
      cyc(0, 1, 1, 4'b0011, 1, ex(1, 0, 2'b00, 1, 0, 0, 1, 1, 0), "div_fetch");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 1, 1, 0, 0, 0), "div_exec0");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 0, 0, 0, 0, 0), "div_exec1");
      cyc(1, 1, 1, 4'b0000, 1, ex(1, 0, 2'b01, 0, 0, 0, 0, 0, 0), "div_exec2_rst");
      cyc(0, 1, 1, 4'b0000, 1, Zero, "abort_reset");
      cyc(0, 1, 1, 4'b0000, 1, ex(1, 0, 2'b00, 1, 0, 0, 1, 1, 0), "abort_fetch");
      for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
      @(posedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Parametrised, multi-cycle control sequencer for the 16-bit CPU.
- Replaces the fixed single-pass control-signal generator.
- Adds fetch stalls (instruction-ROM valid handshake), true two-word instruction sequencing (MVI, LDA), configurable multi-cycle MUL/DIV latency, a separate write-back cycle and illegal-opcode handling.
- Sits between the instruction-split module and the operand registers, ALU, register file and program counter.

Parameters:
- OPCODE_W, 4, opcode width. Must be at least 4. Any nonzero bit above bit 3 makes the opcode illegal.
- ALU_MODE_W, 2, width of the ALU mode output. Must be at least 2. Modes: 00 addressing, 01 arithmetic, 10 logic, 11 reserved.
- MULDIV_LAT, 4, number of EXEC cycles held for MUL/DIV. Must be at least 1.
- CNT_W, $clog2(MULDIV_LAT+1), latency counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable. When low, the FSM holds its state and all strobes are forced to 0.
- imem_valid  in  1  instruction word from ROM is valid this cycle.
- opcode  in  OPCODE_W  opcode field from the instruction-split module.
- alu_mode  out  ALU_MODE_W  ALU operation type.
- ins_load  out  1  latch the instruction word into the split module.
- op1_load  out  1  load operand 1, or capture the immediate for MVI.
- op2_load  out  1  load operand 2.
- pc_load  out  1  present the PC to the instruction ROM.
- pc_inc  out  1  increment the PC.
- reg_load  out  1  write the result to the register file.
- busy  out  1  high in every state except RESET.
- trap  out  1  illegal-opcode trap flag. Present only with CU_ILLEGAL_TRAP_EN; otherwise tied to 0.

Behaviour:
- Reset:
  - rst sampled high: state goes to RESET, op_q and counter clear, trap clears.
  - rst has priority over en.
  - All outputs are registered or decoded from state and are 0 in RESET. alu_mode is never X or Z.
- States: RESET, FETCH, EXT_FETCH, EXEC, WB, TRAP (TRAP only with the macro).
- RESET:
  - Next state is FETCH when en=1.
- FETCH:
  - pc_load=1 every cycle.
  - If imem_valid=0, stay in FETCH (stall, no other strobes).
  - If imem_valid=1:
    - Assert ins_load=1 and pc_inc=1 for that cycle.
    - Capture opcode into op_q.
    - Next state is EXT_FETCH for 1100 (MVI) or 1101 (LDA).
    - Next state is FETCH for illegal opcodes (no macro).
    - Next state is EXEC for all other opcodes.
- EXT_FETCH:
  - pc_load=1 every cycle; stall while imem_valid=0.
  - On imem_valid=1: ins_load=1 and pc_inc=1. For MVI only, also op1_load=1. Next state is EXEC.
  - op_q is not overwritten by the second word.
- EXEC:
  - alu_mode decode:
    - 0000–0011 (ADD, MUL, SUB, DIV) → 01.
    - 0100–1010 (AND, OR, NOR, INV1, INV2, XOR, XNOR) → 10.
    - 1011, 1100, 1101 → 00.
  - Operand strobes, first EXEC cycle only:
    - op1_load=1 for 0000–0111, 1001, 1010.
    - op2_load=1 for 0000–0110, 1000–1011.
  - Latency:
    - MUL (0001) and DIV (0011) stay in EXEC for exactly MULDIV_LAT cycles, counted by the counter.
    - All other opcodes stay 1 cycle.
    - alu_mode is held stable throughout EXEC.
  - Next state is WB.
- WB:
  - reg_load=1 for exactly one cycle.
  - alu_mode holds the EXEC value.
  - Next state is FETCH.
- Cycle counts with imem_valid always 1:
  - 1-word op: 3 cycles (FETCH, EXEC, WB).
  - MUL/DIV: 2+MULDIV_LAT cycles.
  - MVI/LDA: 4 cycles.
- en=0 mid-instruction:
  - State, op_q and the counter freeze; all strobes read 0.
  - The sequence resumes exactly where it stopped when en returns to 1. No strobe is duplicated or lost.
- rst during any state, including a stalled fetch or a MUL count: RESET on the next edge. Any partially executed instruction is abandoned with no reg_load.
- imem_valid is ignored outside FETCH and EXT_FETCH.
- The opcode input is sampled only in FETCH with imem_valid=1.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode (1110, 1111, or any nonzero upper bit) accepted in FETCH moves the FSM to TRAP.
  - In TRAP: trap=1, busy=1, all strobes 0. Only rst exits.
- Undefined:
  - An illegal opcode acts as a 1-cycle NOP. Its FETCH cycle asserts ins_load and pc_inc; the next state is FETCH.
  - No EXEC and no reg_load occur. The trap port is tied to 0.

Test Plan:
- rst=1 for 2 cycles, then en=1, imem_valid=1, opcode=0000 (ADD):
  - All outputs are 0 during reset.
  - FETCH: pc_load=1, ins_load=1, pc_inc=1.
  - EXEC: alu_mode=01, op1_load=1, op2_load=1.
  - WB: reg_load=1.
  - Next FETCH starts at cycle 4.
- opcode=0001 (MUL), MULDIV_LAT=4: EXEC lasts exactly 4 cycles with alu_mode=01; op loads occur only in the first of them; reg_load occurs on the 5th cycle after FETCH.
- opcode=1100 (MVI), imem_valid low for 2 cycles in EXT_FETCH:
  - pc_load is held through the stall.
  - ins_load, pc_inc and op1_load occur once, on the valid cycle.
  - Then EXEC with alu_mode=00, then one reg_load.
- en dropped for 3 cycles in the middle of the MUL EXEC count: strobes are 0 while en is low; the total EXEC cycles with en=1 is still 4; exactly one reg_load.
- opcode=1111:
  - Macro off: no reg_load, and FETCH repeats on the next cycle.
  - Macro on: trap=1 persists across 10 cycles until rst=1 clears it to 0.
- rst asserted during the WB-pending MUL EXEC: no reg_load; RESET outputs are 0 on the next cycle.
